// File: rtl/oclib_pkg.sv
// rtl/oclib_pkg.sv - shared byte-channel types for the oclib blocks
package oclib_pkg;

    // One direction of data/valid paired with the opposite direction's ready.
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

endpackage

// File: rtl/oclib_bc_frame_responder.sv
// rtl/oclib_bc_frame_responder.sv - receives [LEN][payload] frames and echoes them with a checksum
module oclib_bc_frame_responder #(
    parameter int         MaxLen    = 16,
    parameter logic [7:0] ErrorCode = 8'hFF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  oclib_pkg::bc_8b_bidi_s bcIn,
    output oclib_pkg::bc_8b_bidi_s bcOut
);

    localparam int IdxW  = $clog2(MaxLen + 1);
    localparam int AddrW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        DROP,
        TX_LEN,
        TX_DATA,
        TX_CSUM,
        TX_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;       // frame length; counts down remaining bytes in DROP
    logic [IdxW-1:0]   idx_q, idx_d;       // write index in RX, read index in TX_DATA
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              mem_we;
    logic [7:0]        mem_q [MaxLen];

    logic in_acc;
    logic out_acc;

    assign in_acc  = bcIn.valid && ready_q;
    assign out_acc = valid_q && bcIn.ready;

    // Next-state and output-register computation for the frame FSM.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = valid_q;
        ready_d = ready_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (in_acc) begin
                    len_d  = bcIn.data;
                    csum_d = bcIn.data;
                    idx_d  = '0;
                    if (bcIn.data == 8'd0) begin
                        state_d = TX_LEN;
                        valid_d = 1'b1;
                        data_d  = 8'h00;
                        ready_d = 1'b0;
                    end else if (bcIn.data <= 8'(MaxLen)) begin
                        state_d = RX;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            RX: begin
                if (in_acc) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    csum_d = csum_q + bcIn.data;
                    if (8'(idx_q) + 8'd1 == len_q) begin
                        state_d = TX_LEN;
                        valid_d = 1'b1;
                        data_d  = len_q;
                        ready_d = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            DROP: begin
                if (in_acc) begin
                    len_d = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        state_d = TX_ERR;
                        valid_d = 1'b1;
                        data_d  = ErrorCode;
                        ready_d = 1'b0;
                    end
                end
            end
            TX_LEN: begin
                if (out_acc) begin
                    if (len_q == 8'd0) begin
                        state_d = TX_CSUM;
                        data_d  = csum_q;
                    end else begin
                        state_d = TX_DATA;
                        data_d  = mem_q[0];
                        idx_d   = IdxW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (out_acc) begin
                    if (8'(idx_q) == len_q) begin
                        state_d = TX_CSUM;
                        data_d  = csum_q;
                    end else begin
                        data_d = mem_q[idx_q[AddrW-1:0]];
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            TX_CSUM, TX_ERR: begin
                if (out_acc) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = 8'h00;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // FSM and output registers; reset abandons any frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= 8'h00;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Payload buffer; contents need no reset since reads only follow a full RX.
    always_ff @(posedge clock) begin
        if (mem_we && (8'(idx_q) < 8'(MaxLen))) begin
            mem_q[idx_q[AddrW-1:0]] <= bcIn.data;
        end
    end

    assign bcOut = '{data: data_q, valid: valid_q, ready: ready_q};

endmodule

// File: tb/tb_oclib_bc_frame_responder.sv
// tb/tb_oclib_bc_frame_responder.sv - directed self-checking bench for oclib_bc_frame_responder
module tb_oclib_bc_frame_responder;

    logic                   clk;
    logic                   rst;
    oclib_pkg::bc_8b_bidi_s bc_in;
    oclib_pkg::bc_8b_bidi_s bc_out;

    int n_vec = 0;
    int n_err = 0;

    oclib_bc_frame_responder #(.MaxLen(16), .ErrorCode(8'hFF)) dut (
        .clock (clk),
        .reset (rst),
        .bcIn  (bc_in),
        .bcOut (bc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one request byte from a negedge; returns at the negedge after it is accepted.
    task automatic push(input logic [7:0] b);
        logic acc;
        logic took;
        bc_in.valid = 1'b1;
        bc_in.data  = b;
        took = 1'b0;
        for (int n = 0; n < 100 && !took; n++) begin
            acc = bc_out.ready;
            @(negedge clk);
            if (acc) took = 1'b1;
        end
        check($sformatf("push_%02h", b), 32'(took), 32'd1);
    endtask

    task automatic send(input logic [7:0] b [$]);
        foreach (b[i]) push(b[i]);
        bc_in.valid = 1'b0;
    endtask

    // Collect a response, checking bytes, hold-while-stalled, latency and the return to IDLE.
    task automatic expect_resp(input string tag, input logic [7:0] exp [$], input bit bp);
        int         k     = 0;
        int         cyc   = 0;
        int         first = -1;
        int         last  = -1;
        logic       pv    = 1'b0;
        logic       pr    = 1'b0;
        logic [7:0] pd    = 8'h00;
        while (k < exp.size() && cyc < 400) begin
            bc_in.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr) begin
                check({tag, "_hold_valid"}, 32'(bc_out.valid), 32'd1);
                check({tag, "_hold_data"}, 32'(bc_out.data), 32'(pd));
            end
            if (bc_out.valid) check({tag, "_ready_low"}, 32'(bc_out.ready), 32'd0);
            if (bc_out.valid && bc_in.ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                check($sformatf("%s_byte%0d", tag, k), 32'(bc_out.data), 32'(exp[k]));
                k++;
            end
            pv = bc_out.valid;
            pr = bc_in.ready;
            pd = bc_out.data;
            @(negedge clk);
            cyc++;
        end
        bc_in.ready = 1'b0;
        check({tag, "_count"}, 32'(k), 32'(exp.size()));
        if (!bp) begin
            check({tag, "_first_cycle"}, 32'(first), 32'd0);
            check({tag, "_last_cycle"}, 32'(last), 32'(exp.size() - 1));
        end
        check({tag, "_idle_valid"}, 32'(bc_out.valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bc_out.ready), 32'd1);
    endtask

    initial begin
        logic [7:0] req [$];
        logic [7:0] rsp [$];
        bit         saw_valid;

        rst   = 1'b1;
        bc_in = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bc_out.valid), 32'd0);
        check("rst_ready", 32'(bc_out.ready), 32'd0);
        check("rst_data", 32'(bc_out.data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bc_out.ready), 32'd1);
        check("post_rst_valid", 32'(bc_out.valid), 32'd0);

        // Basic frame, no backpressure.
        req = '{8'h03, 8'h01, 8'h02, 8'h03};
        rsp = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        send(req);
        expect_resp("len3", rsp, 1'b0);

        // Empty frame.
        req = '{8'h00};
        rsp = '{8'h00, 8'h00};
        send(req);
        expect_resp("len0", rsp, 1'b0);

        // Full-size frame: 0x10 + 16*0xFF wraps to 0x00.
        req = '{8'h10};
        rsp = '{8'h10};
        for (int i = 0; i < 16; i++) begin
            req.push_back(8'hFF);
            rsp.push_back(8'hFF);
        end
        rsp.push_back(8'h00);
        send(req);
        expect_resp("len16", rsp, 1'b0);

        // Oversize frame: only the error byte comes back.
        req = '{8'h11};
        for (int i = 0; i < 17; i++) req.push_back(8'(i));
        rsp = '{8'hFF};
        send(req);
        expect_resp("len17", rsp, 1'b0);

        req = '{8'h01, 8'h5A};
        rsp = '{8'h01, 8'h5A, 8'h5B};
        send(req);
        expect_resp("after_err", rsp, 1'b0);

        // Same basic frame with random response backpressure.
        req = '{8'h03, 8'h01, 8'h02, 8'h03};
        rsp = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        send(req);
        expect_resp("len3_bp", rsp, 1'b1);

        // Reset mid-frame, then confirm nothing leaks out.
        push(8'h05);
        push(8'h11);
        push(8'h22);
        bc_in.valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(bc_out.valid), 32'd0);
        check("midrst_ready", 32'(bc_out.ready), 32'd0);
        check("midrst_data", 32'(bc_out.data), 32'd0);
        rst = 1'b0;
        bc_in.ready = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bc_out.valid) saw_valid = 1'b1;
        end
        bc_in.ready = 1'b0;
        check("midrst_no_resp", 32'(saw_valid), 32'd0);
        req = '{8'h02, 8'hAA, 8'h55};
        rsp = '{8'h02, 8'hAA, 8'h55, 8'h01};
        send(req);
        expect_resp("after_rst", rsp, 1'b0);

        // Request byte offered throughout a response stays pending until IDLE.
        push(8'h01);
        push(8'h7E);
        bc_in.data = 8'h03;
        rsp = '{8'h01, 8'h7E, 8'h7F};
        expect_resp("pending", rsp, 1'b1);
        @(negedge clk);
        req = '{8'h01, 8'h02, 8'h03};
        rsp = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        send(req);
        expect_resp("pending_frame", rsp, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oclib_bc_frame_responder.md
OCLIB_BC_FRAME_RESPONDER -- requirements
Module: oclib_bc_frame_responder

Interface
REQ-001 SHALL have parameter MaxLen, default 16: payload buffer depth in bytes, legal range 1..254.
REQ-002 SHALL have parameter ErrorCode, default 8'hFF: single-byte response sent for an oversize frame.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port bcIn, input, oclib_pkg::bc_8b_bidi_s: .data/.valid carry request bytes from the initiator; .ready is the initiator's readiness for response bytes.
REQ-006 SHALL have port bcOut, output, oclib_pkg::bc_8b_bidi_s: .data/.valid carry response bytes; .ready is this block's readiness for request bytes.

Function
REQ-007 SHALL transfer a byte in either direction only in a cycle where valid and ready are both high.
REQ-008 SHALL treat a request frame as [LEN][LEN payload bytes], where LEN is unsigned 8-bit.
REQ-009 SHALL use states IDLE, RX, DROP, TX_LEN, TX_DATA, TX_CSUM and TX_ERR.
REQ-010 SHALL drive bcOut.ready high only in IDLE, RX and DROP, and low in every TX state.
REQ-011 SHALL, in IDLE on LEN accept: go to TX_LEN if LEN==0; go to RX if 1<=LEN<=MaxLen; go to DROP if LEN>MaxLen.
REQ-012 SHALL, in RX, write each accepted byte to the buffer at an incrementing index, and go to TX_LEN the cycle after the LENth byte is accepted.
REQ-013 SHALL, in DROP, consume and discard exactly LEN bytes, then go to TX_ERR.
REQ-014 SHALL send the response [LEN][payload in arrival order][CSUM], where CSUM = (LEN + sum of payload bytes) mod 256.
REQ-015 SHALL send [00][00] for a LEN==0 frame.
REQ-016 SHALL send only the single byte ErrorCode for an oversize frame, with no payload and no CSUM.
REQ-017 SHALL drive bcOut.valid and bcOut.data from registers.
REQ-018 SHALL, once bcOut.valid rises, hold bcOut.valid and bcOut.data stable until the byte is accepted.
REQ-019 SHALL assert bcOut.valid with LEN in the cycle after the final request byte (or the LEN byte, when LEN==0) is accepted.
REQ-020 SHALL, when bcIn.ready is held high, present one response byte per cycle with no idle cycles between bytes.
REQ-021 SHALL return to IDLE the cycle after CSUM or ErrorCode is accepted, with bcOut.ready high in that cycle.
REQ-022 SHALL accumulate CSUM with an 8-bit wrapping adder, updated as bytes are received.
REQ-023 SHALL use a buffer index of width $clog2(MaxLen+1), and SHALL never write beyond index MaxLen-1.
REQ-024 SHALL not depend on bcIn.data or bcIn.valid in TX states; request bytes offered then stay pending until IDLE.
REQ-025 SHALL ignore bcIn.ready outside TX states.

Reset
REQ-026 SHALL, while reset is high, force state IDLE, bcOut.valid=0, bcOut.ready=0, bcOut.data=0, CSUM=0 and index=0.
REQ-027 SHALL raise bcOut.ready in the first cycle after reset deasserts.
REQ-028 SHALL, on reset during any state, abandon the frame in progress and discard buffered data.
REQ-029 SHALL never emit a partial response after reset.
REQ-030 SHALL not require the buffer contents themselves to be reset.

Verification
REQ-031 SHALL cover: request 03 01 02 03 with bcIn.ready=1 -> response 03 01 02 03 09 on consecutive cycles, LEN byte one cycle after byte 03 is accepted.
REQ-032 SHALL cover: request 00 -> response 00 00, then return to IDLE.
REQ-033 SHALL cover: request LEN=16 with 16 bytes of FF -> response 10, sixteen FF bytes, 00; then LEN=17 with 17 bytes -> single FF only, and a following frame 01 5A -> response 01 5A 5B.
REQ-034 SHALL cover: random bcIn.ready (about 50% duty) during a response -> bcOut.valid and bcOut.data never change while valid=1 and ready=0, and the byte sequence matches the no-backpressure case.
REQ-035 SHALL cover: reset pulsed after the 2nd payload byte of LEN=5 -> outputs take reset values, no response bytes appear, and a subsequent frame 02 AA 55 -> response 02 AA 55 01.
REQ-036 SHALL cover: request bytes offered with valid=1 during TX -> bcOut.ready=0, and no such byte is consumed until the response completes.
